// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo definitions: bus widths, requester count, opcodes.
// Ports: none (package); op_wb() tells whether an opcode writes the RF.
package cdb_arbiter_pkg;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0100,
    OP_DIV = 4'b0101
  } opcode_t;

  function automatic logic op_wb(input logic [3:0] op);
    unique case (1'b1)
      op == OP_ADD: return 1'b1;
      op == OP_SUB: return 1'b1;
      op == OP_MUL: return 1'b1;
      op == OP_DIV: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Ports: req, ptr in; one-hot grant and binary index idx out.
module cdb_arbiter_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one round-robin grant per cycle, registered
// onto the CDB broadcast and RF write port.
// Ports: clock, reset_n; req/req_data/req_tag/req_dest/req_wb, stall in;
// grant (comb), cdb_valid/data/tag, rf_wen/addr/data, bcast_cnt out.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ_P  = N_REQ,
  parameter int DATA_W_P = DATA_W,
  parameter int TAG_W_P  = TAG_W,
  parameter int REG_W_P  = REG_W
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_REQ_P-1:0]           req,
  input  logic [N_REQ_P*DATA_W_P-1:0]  req_data,
  input  logic [N_REQ_P*TAG_W_P-1:0]   req_tag,
  input  logic [N_REQ_P*REG_W_P-1:0]   req_dest,
  input  logic [N_REQ_P-1:0]           req_wb,
  input  logic                         stall,
  output logic [N_REQ_P-1:0]           grant,
  output logic                         cdb_valid,
  output logic [DATA_W_P-1:0]          cdb_data,
  output logic [TAG_W_P-1:0]           cdb_tag,
  output logic                         rf_wen,
  output logic [REG_W_P-1:0]           rf_addr,
  output logic [DATA_W_P-1:0]          rf_data,
  output logic [15:0]                  bcast_cnt
);

  localparam int IDX_W = $clog2(N_REQ_P);

  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [N_REQ_P-1:0]  pick;
  logic                xfer;
  logic [DATA_W_P-1:0] w_data;
  logic [TAG_W_P-1:0]  w_tag;
  logic [REG_W_P-1:0]  w_dest;

  cdb_arbiter_rr_picker #(
    .N_REQ (N_REQ_P),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick),
    .idx   (win)
  );

  // Grant is suppressed during reset so no unit sees a phantom transfer.
  assign grant = (reset_n && !stall) ? pick : '0;
  assign xfer  = |grant;

  assign w_data = req_data[win*DATA_W_P +: DATA_W_P];
  assign w_tag  = req_tag[win*TAG_W_P +: TAG_W_P];
  assign w_dest = req_dest[win*REG_W_P +: REG_W_P];

  assign ptr_nxt = (win == IDX_W'(N_REQ_P-1)) ? '0 : win + 1'b1;

  assign rf_data = cdb_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cdb_valid <= 1'b0;
      rf_wen    <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      rf_addr   <= '0;
      bcast_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      cdb_valid <= xfer;
      rf_wen    <= xfer & req_wb[win] & (w_dest != '0);
      if (xfer) begin
        cdb_data  <= w_data;
        cdb_tag   <= w_tag;
        rf_addr   <= w_dest;
        bcast_cnt <= bcast_cnt + 16'd1;
        rr_ptr    <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus
// random held requests with stalls; expected CDB results are queued.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int RW = 3;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            stall;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wb;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N*RW-1:0] req_dest;
  logic [N-1:0]    grant;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [TW-1:0]   cdb_tag;
  logic            rf_wen;
  logic [RW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;
  logic [15:0]     bcast_cnt;

  logic [DW-1:0] u_data[N];
  logic [TW-1:0] u_tag[N];
  logic [RW-1:0] u_dest[N];

  always #5 clock = ~clock;

  always_comb begin
    req_data = '0;
    req_tag  = '0;
    req_dest = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = u_data[i];
      req_tag[i*TW +: TW]  = u_tag[i];
      req_dest[i*RW +: RW] = u_dest[i];
    end
  end

  cdb_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_dest  (req_dest),
    .req_wb    (req_wb),
    .stall     (stall),
    .grant     (grant),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .rf_wen    (rf_wen),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .bcast_cnt (bcast_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic [RW-1:0] a;
    logic          w;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  int            m_ptr = 0;
  logic [15:0]   m_cnt = '0;
  logic [DW-1:0] m_data = '0;
  logic [TW-1:0] m_tag = '0;
  logic [RW-1:0] m_addr = '0;
  logic [N-1:0]  last_g;
  int            cyc_valid_run;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    int j;
    if (!reset_n || stall) return '0;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req[j]) return N'(1 << j);
    end
    return '0;
  endfunction

  // Called just after a negedge with inputs already driven;
  // returns just after the following negedge.
  task automatic cycle();
    logic [N-1:0] g;
    exp_t         e;
    int           w;
    #1;
    g = m_grant();
    chk("grant", 32'(grant), 32'(g));
    last_g = g;
    if (!reset_n) begin
      q.delete();
      m_ptr  = 0;
      m_cnt  = '0;
      m_data = '0;
      m_tag  = '0;
      m_addr = '0;
    end else if (g != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (g[i]) w = i;
      e.d = u_data[w];
      e.t = u_tag[w];
      e.a = u_dest[w];
      e.w = req_wb[w] && (u_dest[w] != '0);
      q.push_back(e);
      m_ptr = (w + 1) % N;
      m_cnt = m_cnt + 16'd1;
    end
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cdb_valid", 32'(cdb_valid), 32'd1);
      chk("cdb_data", 32'(cdb_data), 32'(e.d));
      chk("cdb_tag", 32'(cdb_tag), 32'(e.t));
      chk("rf_wen", 32'(rf_wen), 32'(e.w));
      chk("rf_addr", 32'(rf_addr), 32'(e.a));
      chk("rf_data", 32'(rf_data), 32'(e.d));
      m_data = e.d;
      m_tag  = e.t;
      m_addr = e.a;
      cyc_valid_run++;
    end else begin
      chk("idle_valid", 32'(cdb_valid), 32'd0);
      chk("idle_wen", 32'(rf_wen), 32'd0);
      chk("hold_data", 32'(cdb_data), 32'(m_data));
      chk("hold_tag", 32'(cdb_tag), 32'(m_tag));
      chk("hold_addr", 32'(rf_addr), 32'(m_addr));
      cyc_valid_run = 0;
    end
    chk("bcast_cnt", 32'(bcast_cnt), 32'(m_cnt));
    @(negedge clock);
  endtask

  task automatic set_unit(input int i, input logic [DW-1:0] d,
                          input logic [TW-1:0] t, input logic [RW-1:0] a,
                          input logic wb);
    u_data[i] = d;
    u_tag[i]  = t;
    u_dest[i] = a;
    req_wb[i] = wb;
  endtask

  int wait_x[N];

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    req     = '0;
    req_wb  = '0;
    for (int i = 0; i < N; i++) set_unit(i, '0, '0, '0, 1'b0);
    cyc_valid_run = 0;
    @(negedge clock);

    // Reset with all units requesting.
    req = 3'b111;
    for (int i = 0; i < N; i++)
      set_unit(i, DW'(16'h1000 + i), TW'(i + 1), RW'(i + 1), 1'b1);
    cycle();
    cycle();
    chk("rst_data", 32'(cdb_data), 32'd0);
    chk("rst_cnt", 32'(bcast_cnt), 32'd0);

    // Single request from unit 1.
    reset_n = 1'b1;
    req = 3'b010;
    set_unit(1, 16'h00AB, 3'd5, 3'd3, 1'b1);
    cycle();
    chk("single_g", 32'(last_g), 32'(3'b010));
    req = '0;
    cycle();

    // Pointer now at 2: full request rotates 100,001,010,...
    req = 3'b111;
    for (int i = 0; i < N; i++)
      set_unit(i, DW'(16'h2000 + i), TW'(i), RW'(i + 4), 1'b1);
    for (int c = 0; c < 6; c++) cycle();
    chk("rr_run", 32'(cyc_valid_run), 32'd6);
    chk("rr_cnt", 32'(bcast_cnt), 32'd7);
    req = '0;
    cycle();

    // Stall three cycles, then release.
    req = 3'b001;
    stall = 1'b1;
    set_unit(0, 16'h3333, 3'd2, 3'd6, 1'b1);
    for (int c = 0; c < 3; c++) cycle();
    stall = 1'b0;
    cycle();
    chk("stall_rel", 32'(last_g), 32'(3'b001));

    // Writes to r0 and non-writeback results still broadcast.
    req = 3'b100;
    set_unit(2, 16'h4444, 3'd7, 3'd0, 1'b1);
    cycle();
    set_unit(2, 16'h5555, 3'd6, 3'd4, 1'b0);
    cycle();
    req = '0;
    cycle();

    // Reset mid-stream.
    req = 3'b111;
    for (int c = 0; c < 2; c++) cycle();
    reset_n = 1'b0;
    cycle();
    chk("mid_rst_cnt", 32'(bcast_cnt), 32'd0);
    reset_n = 1'b1;
    cycle();
    chk("post_rst_g", 32'(last_g), 32'(3'b001));

    // Random held requests with stalls; fairness tracking.
    req = '0;
    for (int i = 0; i < N; i++) wait_x[i] = 0;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(1, 0) == 1)) begin
          req[i] = 1'b1;
          set_unit(i, DW'($urandom), TW'($urandom), RW'($urandom),
                   op_wb(4'($urandom)));
        end
      end
      stall = ($urandom_range(4, 0) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (last_g[i]) begin
          chk("fair", 32'(wait_x[i] < N), 32'd1);
          wait_x[i] = 0;
          req[i] = 1'b0;
        end else if (req[i] && last_g != '0) begin
          wait_x[i]++;
        end
      end
    end
    stall = 1'b0;
    req = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
